// File: rtl/spi_burst_engine_pkg.sv
`default_nettype none
//==============================================================================
// Module      : spi_burst_engine_pkg
// Description : Shared definitions for the SPI burst sequencer: FSM state
//               encodings, the fill byte sent on an empty TX FIFO, and the
//               default chip-select setup/hold cycle counts.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package spi_burst_engine_pkg;

   // Burst sequencer states
   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_SETUP = 3'd1;
   localparam logic [2:0] c_ST_ISSUE = 3'd2;
   localparam logic [2:0] c_ST_WAIT  = 3'd3;
   localparam logic [2:0] c_ST_HOLD  = 3'd4;

   // Byte shifted out when the TX FIFO runs dry (fill-enabled builds)
   localparam logic [7:0] c_FILL_BYTE = 8'hFF;

   // Default chip-select timing, in clk cycles
   localparam int c_DEFAULT_CS_SETUP = 2;
   localparam int c_DEFAULT_CS_HOLD  = 2;

endpackage : spi_burst_engine_pkg
`default_nettype wire

// File: rtl/spi_burst_engine_byte_fifo.sv
`default_nettype none
//==============================================================================
// Module      : spi_burst_engine_byte_fifo
// Description : Synchronous show-ahead FIFO used for the TX and RX byte queues.
//               Push and pop may occur in the same cycle in any state; a push
//               into a full FIFO is accepted only when a pop frees the slot in
//               the same cycle, a pop on an empty FIFO is dropped.
// Ports       : clk, rst (async, active-high)
//               wr/din   - push request and data
//               rd       - pop request
//               dout     - head entry, valid while !empty
//               full     - occupancy == DEPTH
//               empty    - occupancy == 0
// Revision    : 1.0 - initial release
//==============================================================================
module spi_burst_engine_byte_fifo #(
   parameter int DEPTH = 16,            // power of two, >= 4
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
   localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic             w_push;
   logic             w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == c_FULL_CNT);
   assign dout   = r_mem[r_rd_ptr];
   assign w_pop  = rd && !empty;
   assign w_push = wr && (!full || w_pop);

   // Storage needs no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : spi_burst_engine_byte_fifo
`default_nettype wire

// File: rtl/spi_burst_engine.sv
`default_nettype none
//==============================================================================
// Module      : spi_burst_engine
// Description : Multi-byte SPI burst sequencer between the command/UART layer
//               and spi_host. Outgoing bytes are queued in a TX FIFO and sent
//               burst_len at a time under one chip-select window; received
//               bytes are queued in an RX FIFO for upstream to drain.
// Build macro : SPI_BURST_FILL_EN - when defined, an empty TX FIFO does not
//               stall a burst; 8'hFF is shifted out instead.
// Ports       : clk, rst (async, active-high)
//               start/burst_len/keep_cs - burst command (sampled in IDLE)
//               busy/done               - burst status
//               tx_wr/tx_din/tx_full    - TX FIFO push side
//               rx_rd/rx_dout/rx_empty  - RX FIFO pop side (show-ahead)
//               transfer_req/ready/done, to_agent/from_agent - spi_host link
//               cs_n                    - SPI chip select, active-low
// Revision    : 1.0 - initial release
//==============================================================================
module spi_burst_engine
   import spi_burst_engine_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16,
   parameter int CS_SETUP   = c_DEFAULT_CS_SETUP,   // >= 1
   parameter int CS_HOLD    = c_DEFAULT_CS_HOLD     // >= 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             keep_cs,
   output logic             busy,
   output logic             done,
   input  logic             tx_wr,
   input  logic [7:0]       tx_din,
   output logic             tx_full,
   input  logic             rx_rd,
   output logic [7:0]       rx_dout,
   output logic             rx_empty,
   output logic             transfer_req,
   input  logic             transfer_ready,
   input  logic             transfer_done,
   output logic [7:0]       to_agent,
   input  logic [7:0]       from_agent,
   output logic             cs_n
);

   localparam int c_TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
   localparam logic [c_TMR_W-1:0] c_SETUP_LAST = c_TMR_W'(CS_SETUP - 1);
   localparam logic [c_TMR_W-1:0] c_HOLD_LAST  = c_TMR_W'(CS_HOLD - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
   localparam logic [LEN_W-1:0]   c_LEN_ONE    = LEN_W'(1);

   logic [2:0]         r_state;
   logic               r_busy;
   logic               r_done;
   logic               r_req;
   logic               r_cs_n;
   logic               r_keep_cs;
   logic [7:0]         r_to_agent;
   logic [LEN_W-1:0]   r_remaining;
   logic [c_TMR_W-1:0] r_timer;

   logic [7:0]         w_tx_head;
   logic [7:0]         w_tx_byte;
   logic               w_tx_empty;
   logic               w_rx_full;
   logic               w_tx_ok;
   logic               w_can_issue;
   logic               w_tx_pop;
   logic               w_rx_push;

   //---------------------------------------------------------------------------
   // Issue qualification
   //---------------------------------------------------------------------------
`ifdef SPI_BURST_FILL_EN
   assign w_tx_ok = 1'b1;
`else
   assign w_tx_ok = !w_tx_empty;
`endif

   // The fill byte can only reach to_agent in fill-enabled builds, because
   // otherwise an empty TX FIFO never qualifies an issue.
   assign w_tx_byte = w_tx_empty ? c_FILL_BYTE : w_tx_head;

   // At most one byte is ever in flight and it lands in the RX FIFO before
   // the FSM returns to ISSUE, so "not full" here already accounts for it.
   assign w_can_issue = (r_state == c_ST_ISSUE) && transfer_ready &&
                        w_tx_ok && !w_rx_full;
   assign w_tx_pop    = w_can_issue && !w_tx_empty;
   assign w_rx_push   = (r_state == c_ST_WAIT) && transfer_done;

   //---------------------------------------------------------------------------
   // Byte FIFOs
   //---------------------------------------------------------------------------
   spi_burst_engine_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (tx_wr),
      .din   (tx_din),
      .rd    (w_tx_pop),
      .dout  (w_tx_head),
      .full  (tx_full),
      .empty (w_tx_empty)
   );

   spi_burst_engine_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (w_rx_push),
      .din   (from_agent),
      .rd    (rx_rd),
      .dout  (rx_dout),
      .full  (w_rx_full),
      .empty (rx_empty)
   );

   //---------------------------------------------------------------------------
   // Burst sequencer and chip-select timer
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_req       <= 1'b0;
         r_cs_n      <= 1'b1;
         r_keep_cs   <= 1'b0;
         r_to_agent  <= 8'h00;
         r_remaining <= '0;
         r_timer     <= '0;
      end else begin
         r_req  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  if (burst_len == '0) begin
                     // Empty burst: acknowledge only, chip select untouched.
                     r_done <= 1'b1;
                  end else begin
                     r_remaining <= burst_len;
                     r_keep_cs   <= keep_cs;
                     r_busy      <= 1'b1;
                     r_cs_n      <= 1'b0;
                     r_timer     <= '0;
                     // cs_n still low from a keep_cs burst: setup already met.
                     r_state     <= r_cs_n ? c_ST_SETUP : c_ST_ISSUE;
                  end
               end
            end

            c_ST_SETUP: begin
               if (r_timer == c_SETUP_LAST) begin
                  r_timer <= '0;
                  r_state <= c_ST_ISSUE;
               end else begin
                  r_timer <= r_timer + c_TMR_ONE;
               end
            end

            c_ST_ISSUE: begin
               if (w_can_issue) begin
                  r_req      <= 1'b1;
                  r_to_agent <= w_tx_byte;
                  r_state    <= c_ST_WAIT;
               end
            end

            c_ST_WAIT: begin
               if (transfer_done) begin
                  r_remaining <= r_remaining - c_LEN_ONE;
                  if (r_remaining == c_LEN_ONE) begin
                     r_timer <= '0;
                     r_state <= c_ST_HOLD;
                  end else begin
                     r_state <= c_ST_ISSUE;
                  end
               end
            end

            c_ST_HOLD: begin
               if (r_keep_cs) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_ST_IDLE;
               end else if (r_timer == c_HOLD_LAST) begin
                  r_cs_n  <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_ST_IDLE;
               end else begin
                  r_timer <= r_timer + c_TMR_ONE;
               end
            end

            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign transfer_req = r_req;
   assign to_agent     = r_to_agent;
   assign cs_n         = r_cs_n;

endmodule : spi_burst_engine
`default_nettype wire

// File: tb/tb_spi_burst_engine.sv
`default_nettype none
//==============================================================================
// Module      : tb_spi_burst_engine
// Description : Self-checking bench for spi_burst_engine. A table of burst
//               records drives the main function; hand-written sequences cover
//               RX back-pressure, empty-TX behaviour and mid-burst reset. A
//               spi_host model echoes every byte; expected TX bytes and RX
//               bytes are held in scoreboard queues.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_spi_burst_engine;

   localparam int FIFO_DEPTH = 16;
   localparam int LEN_W      = 16;
   localparam int CS_SETUP   = 2;
   localparam int CS_HOLD    = 2;
   localparam int AGENT_LAT  = 3;
   localparam int NV         = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic             keep_cs;
   logic             busy;
   logic             done;
   logic             tx_wr;
   logic [7:0]       tx_din;
   logic             tx_full;
   logic             rx_rd;
   logic [7:0]       rx_dout;
   logic             rx_empty;
   logic             transfer_req;
   logic             transfer_ready;
   logic             transfer_done;
   logic [7:0]       to_agent;
   logic [7:0]       from_agent;
   logic             cs_n;

   int n_checks = 0;
   int n_fail   = 0;
   int mon_done = 0;
   int mon_req  = 0;
   int ag_cnt   = 0;
   logic [7:0] ag_byte = 8'h00;

   logic [7:0] q_tx [$];
   logic [7:0] q_rx [$];

   typedef struct {
      int          len;
      bit          keep;
      logic [31:0] data;        // byte i at data[8*i +: 8]
      int          exp_pre;     // cs_n-low cycles seen before the first req
      bit          exp_cs_end;  // cs_n when done pulses
   } vec_t;

   vec_t vecs [NV];

   spi_burst_engine #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W),
      .CS_SETUP   (CS_SETUP),
      .CS_HOLD    (CS_HOLD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .burst_len      (burst_len),
      .keep_cs        (keep_cs),
      .busy           (busy),
      .done           (done),
      .tx_wr          (tx_wr),
      .tx_din         (tx_din),
      .tx_full        (tx_full),
      .rx_rd          (rx_rd),
      .rx_dout        (rx_dout),
      .rx_empty       (rx_empty),
      .transfer_req   (transfer_req),
      .transfer_ready (transfer_ready),
      .transfer_done  (transfer_done),
      .to_agent       (to_agent),
      .from_agent     (from_agent),
      .cs_n           (cs_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Event counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (done)         mon_done++;
      if (transfer_req) mon_req++;
   end

   // spi_host model: accepts a request, answers AGENT_LAT cycles later with
   // an echo of the byte the bench expected to be sent.
   always @(posedge clk) begin
      #1;
      transfer_done = 1'b0;
      if (rst) begin
         ag_cnt         = 0;
         transfer_ready = 1'b1;
      end else begin
         if (ag_cnt != 0) begin
            ag_cnt--;
            if (ag_cnt == 0) begin
               check("to_agent_stable", {24'h0, to_agent}, {24'h0, ag_byte});
               from_agent     = ag_byte;
               transfer_done  = 1'b1;
               transfer_ready = 1'b1;
               q_rx.push_back(ag_byte);
            end
         end
         if (transfer_req) begin
            check("req_while_ready", {31'h0, transfer_ready}, 32'h1);
            if (q_tx.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_req: got to_agent=%0h expected no request", to_agent);
               ag_byte = to_agent;
            end else begin
               ag_byte = q_tx.pop_front();
               check("to_agent", {24'h0, to_agent}, {24'h0, ag_byte});
            end
            ag_cnt         = AGENT_LAT;
            transfer_ready = 1'b0;
         end
      end
   end

   task automatic push_tx(input logic [7:0] b);
      @(negedge clk);
      tx_wr  = 1'b1;
      tx_din = b;
      if (q_tx.size() < FIFO_DEPTH) q_tx.push_back(b);
      @(negedge clk);
      tx_wr  = 1'b0;
   endtask

   task automatic start_burst(input logic [LEN_W-1:0] len, input bit keep);
      @(negedge clk);
      start     = 1'b1;
      burst_len = len;
      keep_cs   = keep;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, input string name);
      int k = 0;
      while (mon_done == base && k < budget) begin
         @(posedge clk);
         k++;
      end
      check(name, 32'(mon_done - base), 32'h1);
      @(negedge clk);
   endtask

   task automatic drain(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         while (rx_empty && k < 200) begin
            @(negedge clk);
            k++;
         end
         if (rx_empty || q_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_avail[%0d]: got rx_empty=%0d queued=%0d expected a byte", name, i, rx_empty, q_rx.size());
            return;
         end
         check($sformatf("%s_byte[%0d]", name, i), {24'h0, rx_dout}, {24'h0, q_rx.pop_front()});
         rx_rd = 1'b1;
         @(negedge clk);
         rx_rd = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int pre = 0, hold = 0, reqs = 0, dones = 0, tdones = 0, done_k = -1;
      bit after_last = 1'b0, busy_any = 1'b0, cs_low_any = 1'b0;
      logic end_cs = 1'b1, end_busy = 1'b1;
      for (int i = 0; i < v.len; i++) push_tx(v.data[8*i +: 8]);
      start_burst(LEN_W'(v.len), v.keep);
      for (int k = 0; k < 200; k++) begin
         if (transfer_req) reqs++;
         if (reqs == 0 && !transfer_req && !cs_n) pre++;
         if (transfer_done) begin
            tdones++;
            if (tdones == v.len) after_last = 1'b1;
         end else if (after_last && dones == 0 && !cs_n) begin
            hold++;
         end
         if (busy)  busy_any   = 1'b1;
         if (!cs_n) cs_low_any = 1'b1;
         if (done) begin
            dones++;
            end_cs   = cs_n;
            end_busy = busy;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k >= done_k + 3) break;
         @(negedge clk);
      end
      check($sformatf("v%0d_reqs", idx),  32'(reqs),  32'(v.len));
      check($sformatf("v%0d_dones", idx), 32'(dones), 32'h1);
      check($sformatf("v%0d_cs_at_done", idx), {31'h0, end_cs}, {31'h0, v.exp_cs_end});
      check($sformatf("v%0d_busy_at_done", idx), {31'h0, end_busy}, 32'h0);
      if (v.len != 0) begin
         check($sformatf("v%0d_cs_setup", idx), 32'(pre), 32'(v.exp_pre));
         if (!v.keep) check($sformatf("v%0d_cs_hold", idx), 32'(hold), 32'(CS_HOLD));
      end else begin
         check($sformatf("v%0d_done_latency", idx), 32'(done_k), 32'h0);
         check($sformatf("v%0d_busy_seen", idx), {31'h0, busy_any}, 32'h0);
         check($sformatf("v%0d_cs_low_seen", idx), {31'h0, cs_low_any}, 32'h0);
      end
      drain(v.len, $sformatf("v%0d_rx", idx));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int br, bd, k;
      vec_t rv;

      // len, keep, bytes (LSB first), cs-low cycles before first req, cs_n at done
      vecs[0] = '{len: 3, keep: 1'b0, data: 32'h000F3CA5, exp_pre: CS_SETUP + 1, exp_cs_end: 1'b1};
      vecs[1] = '{len: 0, keep: 1'b0, data: 32'h00000000, exp_pre: 0,            exp_cs_end: 1'b1};
      vecs[2] = '{len: 2, keep: 1'b1, data: 32'h00002211, exp_pre: CS_SETUP + 1, exp_cs_end: 1'b0};
      vecs[3] = '{len: 1, keep: 1'b0, data: 32'h00000033, exp_pre: 1,            exp_cs_end: 1'b1};
      vecs[4] = '{len: 4, keep: 1'b0, data: 32'h7EFE8001, exp_pre: CS_SETUP + 1, exp_cs_end: 1'b1};

      rst = 1'b1; start = 1'b0; burst_len = '0; keep_cs = 1'b0;
      tx_wr = 1'b0; tx_din = 8'h00; rx_rd = 1'b0;
      transfer_ready = 1'b1; transfer_done = 1'b0; from_agent = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy",     {31'h0, busy},         32'h0);
      check("rst_done",     {31'h0, done},         32'h0);
      check("rst_req",      {31'h0, transfer_req}, 32'h0);
      check("rst_to_agent", {24'h0, to_agent},     32'h0);
      check("rst_cs_n",     {31'h0, cs_n},         32'h1);
      check("rst_tx_full",  {31'h0, tx_full},      32'h0);
      check("rst_rx_empty", {31'h0, rx_empty},     32'h1);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // TX full, dropped push, then RX back-pressure mid-burst.
      br = mon_req; bd = mon_done;
      for (int i = 0; i < FIFO_DEPTH; i++) push_tx(8'(8'h40 + i));
      check("tx_full_at_depth", {31'h0, tx_full}, 32'h1);
      push_tx(8'hEE);
      check("tx_full_after_drop", {31'h0, tx_full}, 32'h1);
      start_burst(LEN_W'(15), 1'b0);
      wait_done(bd, 400, "fill15_done");
      check("fill15_reqs", 32'(mon_req - br), 32'd15);
      check("fill15_rx_nonempty", {31'h0, rx_empty}, 32'h0);
      push_tx(8'h90);
      push_tx(8'h91);
      br = mon_req; bd = mon_done;
      start_burst(LEN_W'(3), 1'b0);
      repeat (30) @(negedge clk);
      check("rxfull_stall_reqs", 32'(mon_req - br), 32'h1);
      check("rxfull_stall_busy", {31'h0, busy}, 32'h1);
      check("rxfull_stall_cs",   {31'h0, cs_n}, 32'h0);
      drain(18, "rxfull_rx");
      wait_done(bd, 200, "rxfull_done");
      check("rxfull_reqs", 32'(mon_req - br), 32'd3);
      check("rxfull_rx_empty_end", {31'h0, rx_empty}, 32'h1);

      // Empty TX FIFO at burst start.
      br = mon_req; bd = mon_done;
`ifdef SPI_BURST_FILL_EN
      q_tx.push_back(8'hFF);
      q_tx.push_back(8'hFF);
      start_burst(LEN_W'(2), 1'b0);
      wait_done(bd, 200, "txempty_done");
      check("txempty_reqs", 32'(mon_req - br), 32'd2);
`else
      start_burst(LEN_W'(2), 1'b0);
      repeat (20) @(negedge clk);
      check("txempty_stall_reqs", 32'(mon_req - br), 32'h0);
      check("txempty_stall_busy", {31'h0, busy}, 32'h1);
      check("txempty_stall_cs",   {31'h0, cs_n}, 32'h0);
      push_tx(8'h5A);
      push_tx(8'hC3);
      wait_done(bd, 200, "txempty_done");
      check("txempty_reqs", 32'(mon_req - br), 32'd2);
`endif
      drain(2, "txempty_rx");

      // Reset between the second request and its completion.
      push_tx(8'hAA);
      push_tx(8'h55);
      br = mon_req; bd = mon_done;
      start_burst(LEN_W'(2), 1'b0);
      k = 0;
      while ((mon_req - br) < 2 && k < 100) begin
         @(posedge clk);
         k++;
      end
      check("rstseq_second_req", 32'(mon_req - br), 32'd2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstseq_cs_n_async",  {31'h0, cs_n},         32'h1);
      check("rstseq_busy",        {31'h0, busy},         32'h0);
      check("rstseq_req",         {31'h0, transfer_req}, 32'h0);
      check("rstseq_rx_empty",    {31'h0, rx_empty},     32'h1);
      check("rstseq_tx_full",     {31'h0, tx_full},      32'h0);
      check("rstseq_to_agent",    {24'h0, to_agent},     32'h0);
      q_tx.delete();
      q_rx.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rstseq_no_done", 32'(mon_done - bd), 32'h0);
      check("rstseq_rx_still_empty", {31'h0, rx_empty}, 32'h1);
      rv = '{len: 1, keep: 1'b0, data: 32'h00000077, exp_pre: CS_SETUP + 1, exp_cs_end: 1'b1};
      run_vec(rv, 9);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spi_burst_engine
`default_nettype wire
